mul_arb: RTL

- Shares one pipelined integer multiplier datapath between two requesters: port 0 is the integer pipeline MDU and port 1 is a secondary unit such as a crypto or vector helper.
- Performs round-robin arbitration with valid/ready issue handshakes.
- Tracks which requester owns each in-flight operation in a shadow valid/owner pipeline.
- Drives the multiplier's operand, funct3 and stall inputs, and steers the product back with per-requester response handshakes.
- Sits between the requesters and the multiplier instance. The multiplier itself carries no valid bits; this block owns all validity.

---
 rtl/mul_arb_if.sv | 46 ++++
 rtl/mul_arb.sv | 93 +++++++++
 2 files changed

// File: rtl/mul_arb_if.sv
// Bundle of requester, response and multiplier-side signals for mul_arb.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: both requesters plus the multiplier instance.
interface mul_arb_if #(
  parameter int XLEN = 64
);
  logic              Req0Valid;
  logic              Req0Ready;
  logic [XLEN-1:0]   Req0A;
  logic [XLEN-1:0]   Req0B;
  logic [2:0]        Req0Funct3;
  logic              Req0Flush;
  logic              Req1Valid;
  logic              Req1Ready;
  logic [XLEN-1:0]   Req1A;
  logic [XLEN-1:0]   Req1B;
  logic [2:0]        Req1Funct3;
  logic [XLEN-1:0]   MulSrcA;
  logic [XLEN-1:0]   MulSrcB;
  logic [2:0]        MulFunct3;
  logic              MulStall;
  logic [2*XLEN-1:0] MulProd;
  logic              Rsp0Valid;
  logic              Rsp1Valid;
  logic              Rsp0Ready;
  logic              Rsp1Ready;
  logic [2*XLEN-1:0] RspProd;

  modport slave (
    input  Req0Valid, Req0A, Req0B, Req0Funct3, Req0Flush,
    input  Req1Valid, Req1A, Req1B, Req1Funct3,
    input  MulProd, Rsp0Ready, Rsp1Ready,
    output Req0Ready, Req1Ready,
    output MulSrcA, MulSrcB, MulFunct3, MulStall,
    output Rsp0Valid, Rsp1Valid, RspProd
  );

  modport master (
    output Req0Valid, Req0A, Req0B, Req0Funct3, Req0Flush,
    output Req1Valid, Req1A, Req1B, Req1Funct3,
    output MulProd, Rsp0Ready, Rsp1Ready,
    input  Req0Ready, Req1Ready,
    input  MulSrcA, MulSrcB, MulFunct3, MulStall,
    input  Rsp0Valid, Rsp1Valid, RspProd
  );
endinterface

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters.
// The multiplier carries no valid bits. A shadow valid/owner pipeline of LAT
// stages tracks which requester owns each in-flight product. The result stage
// stalls the multiplier until its owner accepts the product.
// ReqNReady depends combinationally on RspNReady, but only through MulStall.
module mul_arb #(
  parameter int XLEN = 64,
  parameter int LAT  = 2
) (
  input logic       clk,
  input logic       reset,
  mul_arb_if.slave  bus
);

  logic [LAT-1:0]  v_q, v_d;
  logic [LAT-1:0]  o_q, o_d;
  logic            last_q, last_d;
  logic            stall;
  logic            req0_eff;
  logic            grant_any;
  logic            grant_own;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [2:0]      src_f3;

  // Result stage holds the pipeline while its owner is not ready.
  always_comb begin
    stall = v_q[LAT-1] & ~(o_q[LAT-1] ? bus.Rsp1Ready : bus.Rsp0Ready);
  end

  // Round-robin grant. A flushed requester-0 offer never competes.
  always_comb begin
    req0_eff  = bus.Req0Valid & ~bus.Req0Flush;
    grant_any = ~stall & (req0_eff | bus.Req1Valid);
    if (req0_eff & bus.Req1Valid) grant_own = ~last_q;
    else                          grant_own = bus.Req1Valid;
  end

  // Operand steering: zeros when nothing is granted.
  always_comb begin
    src_a  = '0;
    src_b  = '0;
    src_f3 = '0;
    if (grant_any) begin
      src_a  = grant_own ? bus.Req1A      : bus.Req0A;
      src_b  = grant_own ? bus.Req1B      : bus.Req0B;
      src_f3 = grant_own ? bus.Req1Funct3 : bus.Req0Funct3;
    end
  end

  // Shadow pipeline next state: shift when unstalled, then flush owner-0 entries.
  always_comb begin
    v_d    = v_q;
    o_d    = o_q;
    last_d = grant_any ? grant_own : last_q;
    if (!stall) begin
      for (int i = LAT - 1; i > 0; i--) begin
        v_d[i] = v_q[i-1];
        o_d[i] = o_q[i-1];
      end
      v_d[0] = grant_any;
      o_d[0] = grant_own;
    end
    if (bus.Req0Flush) v_d = v_d & o_d;
  end

  // Validity and last-grant pointer; the pointer favours requester 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      last_q <= 1'b1;
    end else begin
      v_q    <= v_d;
      last_q <= last_d;
    end
  end

  // Owner tags are only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    o_q <= o_d;
  end

  assign bus.Req0Ready = grant_any & ~grant_own;
  assign bus.Req1Ready = grant_any &  grant_own;
  assign bus.MulSrcA   = src_a;
  assign bus.MulSrcB   = src_b;
  assign bus.MulFunct3 = src_f3;
  assign bus.MulStall  = stall;
  assign bus.Rsp0Valid = v_q[LAT-1] & ~o_q[LAT-1];
  assign bus.Rsp1Valid = v_q[LAT-1] &  o_q[LAT-1];
  assign bus.RspProd   = bus.MulProd;

endmodule
